// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one-at-a-time word requests,
// buffers DEPTH {pc, instr} pairs. Optional same-cycle bypass via FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_adrs,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    input  logic        stall_F,
    input  logic        flush_F,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // fpc is kept as a word address so the low two bits can never be non-zero
    logic [29:0]   fpc_q, fpc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic not_empty;
    logic not_full;
    logic push;
    logic pop;
    logic wr_en;
    logic bypass;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign not_empty  = (count_q != '0);
    assign not_full   = (count_q != FULL_CNT);
    assign fetch_req  = reset & not_full & ~flush_F;
    assign fetch_adrs = {fpc_q, 2'b00};
    assign push       = fetch_req & fetch_ack;
    assign pop        = not_empty & ~stall_F & ~flush_F;

`ifdef FETCH_QUEUE_BYPASS_EN
    // an empty queue hands the returning word straight to decode; only a stall forces storage
    assign bypass = push & ~not_empty;
    assign wr_en  = push & ~(bypass & ~stall_F);
`else
    assign bypass = 1'b0;
    assign wr_en  = push;
`endif

    assign instr_valid = not_empty | bypass;
    assign Instr       = not_empty ? instr_mem_q[rd_ptr_q]
                       : (bypass ? fetch_data : NOP_INSTR);
    assign instr_pc    = not_empty ? pc_mem_q[rd_ptr_q] : {fpc_q, 2'b00};

    always_comb begin
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_F) begin
            fpc_d    = redirect_pc[31:2];
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fpc_d = fpc_q + 30'd1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q    <= RESET_PC[31:2];
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage contents are qualified by count, so they need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]    <= {fpc_q, 2'b00};
            instr_mem_q[wr_ptr_q] <= fetch_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] PAT   = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_adrs;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data;
    logic        stall_F = 1'b0;
    logic        flush_F = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    // zero-wait memory image: each word is its address xor a fixed pattern
    assign fetch_data = fetch_adrs ^ PAT;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(rst_n),
        .fetch_req(fetch_req), .fetch_adrs(fetch_adrs),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .stall_F(stall_F), .flush_F(flush_F), .redirect_pc(redirect_pc),
        .Instr(Instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mfpc = RPC;
    logic [31:0] dlv[$];
    int          n_acc;
    int          checks = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic m_req();
        return rst_n && (mq.size() < DEPTH) && !flush_F;
    endfunction

    function automatic logic m_byp();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && m_req() && fetch_ack;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_valid();
        return (mq.size() != 0) || m_byp();
    endfunction

    function automatic logic [31:0] m_instr();
        if (mq.size() != 0) return mq[0].ins;
        if (m_byp()) return mfpc ^ PAT;
        return NOP;
    endfunction

    function automatic logic [31:0] m_pc();
        if (mq.size() != 0) return mq[0].pc;
        return mfpc;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " req"},   32'(fetch_req),   32'(m_req()));
        chk({tag, " adrs"},  fetch_adrs,       mfpc);
        chk({tag, " valid"}, 32'(instr_valid), 32'(m_valid()));
        chk({tag, " pc"},    instr_pc,         m_pc());
        chk({tag, " instr"}, Instr,            m_instr());
    endtask

    // advances the model to the state after the coming rising edge; also logs DUT deliveries
    task automatic model_update();
        logic acc;
        logic b;
        if (instr_valid && !stall_F && !flush_F) dlv.push_back(instr_pc);
        if (fetch_req && fetch_ack) n_acc++;
        if (!rst_n) return;
        if (flush_F) begin
            mq.delete();
            mfpc = {redirect_pc[31:2], 2'b00};
        end else begin
            acc = m_req() && fetch_ack;
            b   = m_byp();
            if (b && !stall_F) begin
                mfpc = mfpc + 32'd4;
            end else begin
                if (mq.size() != 0 && !stall_F) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back('{pc: mfpc, ins: mfpc ^ PAT});
                    mfpc = mfpc + 32'd4;
                end
            end
        end
    endtask

    task automatic cyc(input logic st, input logic fl, input logic [31:0] rp,
                       input logic ak, input string tag);
        stall_F = st; flush_F = fl; redirect_pc = rp; fetch_ack = ak;
        @(negedge clk);
        check_model(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall_F = 1'b0; flush_F = 1'b0; fetch_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();
        mfpc = RPC;
        #1 rst_n = 1'b1;
    endtask

    task automatic check_dlv(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input int n);
        logic [31:0] exp_list [3];
        exp_list[0] = e0; exp_list[1] = e1; exp_list[2] = e2;
        chk({tag, " count"}, 32'(dlv.size() >= n), 32'd1);
        for (int i = 0; i < n && i < dlv.size(); i++) chk({tag, " pc"}, dlv[i], exp_list[i]);
    endtask

    typedef struct {
        logic        st, fl, ak;
        logic [31:0] rp;
        logic        ereq;
        logic [31:0] eadrs;
        logic        evalid;
        logic [31:0] epc, einstr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic        ak;
        int          wcnt;
        logic        st, fl;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, NOP};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, NOP};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000, 32'hA5A5_A5A5};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000, 32'hA5A5_A5A5};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004, 32'hA5A5_A5A1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h00C, 1'b1, 32'h008, 32'hA5A5_A5AD};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h100, NOP};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h0,   1'b1, 32'h100, 1'b0, 32'h100, NOP};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'hA5A5_A4A5};
`ifdef FETCH_QUEUE_BYPASS_EN
        tbl[1].evalid = 1'b1; tbl[1].einstr = 32'hA5A5_A5A5;
        tbl[7].evalid = 1'b1; tbl[7].einstr = 32'hA5A5_A4A5;
`endif

        // reset values while reset is held
        #2;
        chk("rst req",   32'(fetch_req),   32'd0);
        chk("rst valid", 32'(instr_valid), 32'd0);
        chk("rst instr", Instr,            NOP);
        chk("rst pc",    instr_pc,         RPC);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            stall_F = tbl[i].st; flush_F = tbl[i].fl;
            fetch_ack = tbl[i].ak; redirect_pc = tbl[i].rp;
            @(negedge clk);
            chk($sformatf("vec%0d req", i),   32'(fetch_req),   32'(tbl[i].ereq));
            chk($sformatf("vec%0d adrs", i),  fetch_adrs,       tbl[i].eadrs);
            chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(tbl[i].evalid));
            chk($sformatf("vec%0d pc", i),    instr_pc,         tbl[i].epc);
            chk($sformatf("vec%0d instr", i), Instr,            tbl[i].einstr);
            model_update();
            @(posedge clk);
            #1;
        end

        // zero-wait streaming, one instruction per cycle
        do_reset();
        dlv.delete();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, "stream");
        check_dlv("stream", 32'h0, 32'h4, 32'h8, 3);

        // stall fills the queue to DEPTH, then drains in order
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1, "stallfill");
        chk("stall acks", 32'(n_acc), 32'(DEPTH));
        dlv.delete();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, "drain");
        check_dlv("drain", 32'h0, 32'h4, 32'h8, 3);
        if (dlv.size() >= 4) chk("drain pc3", dlv[3], 32'hC);
        else chk("drain size", 32'(dlv.size()), 32'd4);

        // flush with three entries buffered
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1, "pref");
        cyc(1'b1, 1'b1, 32'h0000_0103, 1'b1, "flush");
        @(negedge clk);
        chk("postflush valid", 32'(instr_valid), 32'd0);
        chk("postflush adrs",  fetch_adrs,       32'h100);
        @(posedge clk); #1;
        dlv.delete();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, "redir");
        check_dlv("redir", 32'h100, 32'h104, 32'h108, 2);

        // memory with a three-cycle ack delay
        do_reset();
        wcnt = 0;
        for (int i = 0; i < 24; i++) begin
            ak = 1'b0;
            if (m_req()) begin
                ak   = (wcnt == 2);
                wcnt = ak ? 0 : wcnt + 1;
            end
            cyc(1'b0, 1'b0, 32'h0, ak, "delay");
        end

        // asynchronous reset mid-stream with 2 entries and a pending request
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, "pre_rst");
        cyc(1'b1, 1'b0, 32'h0, 1'b1, "pre_rst");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, "pre_rst");
        fetch_ack = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(instr_valid), 32'd0);
        chk("midrst instr", Instr,            NOP);
        chk("midrst req",   32'(fetch_req),   32'd0);
        chk("midrst pc",    instr_pc,         RPC);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, "restart");

        // redirect across the top of the address space
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, "wrapflush");
        dlv.delete();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, "wrap");
        check_dlv("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 3);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 5);
            ak = 1'($urandom_range(0, 1));
            cyc(st, fl, $urandom, ak, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
